// File: rtl/l2_refill_arbiter.sv
// Round-robin refill arbiter: two L2 refill ports share one 1-cycle-latency word memory,
// each grant streams a 16-word burst into a 512-bit line. Define REFILL_PERF_EN for perf counters.
module l2_refill_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] DEPTH_WORDS = 32'h3000,
  parameter int          AW          = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_0,
  input  logic [25:0]   addr_0,
  output logic          ready_0,
  input  logic          req_1,
  input  logic [25:0]   addr_1,
  output logic          ready_1,
  output logic [511:0]  line_data,
  output logic          busy,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
`ifdef REFILL_PERF_EN
  ,
  output logic [31:0]   refill_cnt_0,
  output logic [31:0]   refill_cnt_1,
  output logic [31:0]   wait_cycles
`endif
);

  localparam logic [31:0] BASE_WORD = {2'b00, BASE_ADDR[31:2]};

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESP} state_e;

  state_e         state_q;
  logic           gnt_q;
  logic           last_grant_q;
  logic [25:0]    line_q;
  logic [3:0]     cnt_q;
  logic           inv_q;
  logic           inv_dly_q;
  logic           ready_0_q;
  logic           ready_1_q;
  logic [511:0]   line_data_q;
  logic           busy_q;
  logic           mem_en_q;
  logic [AW-1:0]  mem_addr_q;

  logic           grant_s;
  logic [25:0]    fetch_line_s;
  logic [3:0]     fetch_cnt_s;
  logic [31:0]    word_s;
  logic [31:0]    rel_s;
  logic           inv_s;
  logic [3:0]     cap_idx_s;
  logic [31:0]    cap_word_s;

  // Arbitration choice plus address and validity of the next word to be fetched.
  always_comb begin
    grant_s      = 1'b0;
    fetch_line_s = line_q;
    fetch_cnt_s  = cnt_q + 4'd1;
    if (req_0 && req_1) begin
      grant_s = ~last_grant_q;
    end else if (req_1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (state_q == IDLE) begin
      fetch_line_s = grant_s ? addr_1 : addr_0;
      fetch_cnt_s  = 4'd0;
    end else begin
      fetch_line_s = line_q;
      fetch_cnt_s  = cnt_q + 4'd1;
    end
    // Words below the base or past the end of memory read back as zero.
    word_s     = {2'b00, fetch_line_s, fetch_cnt_s};
    rel_s      = word_s - BASE_WORD;
    inv_s      = (word_s < BASE_WORD) || (rel_s >= DEPTH_WORDS);
    cap_idx_s  = (state_q == DRAIN) ? 4'd15 : (cnt_q - 4'd1);
    cap_word_s = inv_dly_q ? 32'h0 : mem_rdata;
  end

  // Refill sequencer: grant, 16-cycle burst, drain of the last read, ready pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      line_q       <= 26'd0;
      cnt_q        <= 4'd0;
      inv_q        <= 1'b0;
      inv_dly_q    <= 1'b0;
      ready_0_q    <= 1'b0;
      ready_1_q    <= 1'b0;
      line_data_q  <= 512'd0;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      inv_dly_q <= inv_q;
      case (state_q)
        IDLE: begin
          if (req_0 || req_1) begin
            state_q      <= BURST;
            busy_q       <= 1'b1;
            gnt_q        <= grant_s;
            last_grant_q <= grant_s;
            line_q       <= fetch_line_s;
            cnt_q        <= 4'd0;
            mem_en_q     <= 1'b1;
            mem_addr_q   <= rel_s[AW-1:0];
            inv_q        <= inv_s;
          end
        end
        BURST: begin
          if (cnt_q != 4'd0) begin
            line_data_q[{cap_idx_s, 5'd0} +: 32] <= cap_word_s;
          end
          if (cnt_q == 4'd15) begin
            state_q  <= DRAIN;
            mem_en_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + 4'd1;
            mem_addr_q <= rel_s[AW-1:0];
            inv_q      <= inv_s;
          end
        end
        DRAIN: begin
          line_data_q[{cap_idx_s, 5'd0} +: 32] <= cap_word_s;
          state_q   <= RESP;
          ready_0_q <= ~gnt_q;
          ready_1_q <= gnt_q;
        end
        RESP: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          ready_0_q <= 1'b0;
          ready_1_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          mem_en_q  <= 1'b0;
          ready_0_q <= 1'b0;
          ready_1_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_0   = ready_0_q;
  assign ready_1   = ready_1_q;
  assign line_data = line_data_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;

`ifdef REFILL_PERF_EN
  logic [31:0] refill_cnt_0_q;
  logic [31:0] refill_cnt_1_q;
  logic [31:0] wait_cycles_q;

  // Saturating completion counters and cycles a losing request spends waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refill_cnt_0_q <= 32'd0;
      refill_cnt_1_q <= 32'd0;
      wait_cycles_q  <= 32'd0;
    end else begin
      if (ready_0_q && (refill_cnt_0_q != 32'hFFFF_FFFF)) begin
        refill_cnt_0_q <= refill_cnt_0_q + 32'd1;
      end
      if (ready_1_q && (refill_cnt_1_q != 32'hFFFF_FFFF)) begin
        refill_cnt_1_q <= refill_cnt_1_q + 32'd1;
      end
      if ((state_q != IDLE) && (gnt_q ? req_0 : req_1) && (wait_cycles_q != 32'hFFFF_FFFF)) begin
        wait_cycles_q <= wait_cycles_q + 32'd1;
      end
    end
  end

  assign refill_cnt_0 = refill_cnt_0_q;
  assign refill_cnt_1 = refill_cnt_1_q;
  assign wait_cycles  = wait_cycles_q;
`endif

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Self-checking bench for l2_refill_arbiter: directed table, multi-cycle corner sequences
// and randomized traffic checked against a byte-address level reference model.
module tb_l2_refill_arbiter;

  logic         clk;
  logic         rstn;
  logic         sel;
  logic         req0_v, req1_v;
  logic [25:0]  addr0_v, addr1_v;

  logic         a_req_0, a_req_1, a_ready_0, a_ready_1, a_busy, a_mem_en;
  logic [511:0] a_line;
  logic [13:0]  a_mem_addr;
  logic [31:0]  a_mem_rdata;
  logic         b_req_0, b_req_1, b_ready_0, b_ready_1, b_busy, b_mem_en;
  logic [511:0] b_line;
  logic [5:0]   b_mem_addr;
  logic [31:0]  b_mem_rdata;
`ifdef REFILL_PERF_EN
  logic [31:0]  a_rc0, a_rc1, a_wait, b_rc0, b_rc1, b_wait;
`endif

  logic         obs_ready0, obs_ready1, obs_busy, obs_mem_en;
  logic [511:0] obs_line;
  logic [31:0]  obs_mem_addr;

  int n_checks;
  int n_fail;

  assign a_req_0 = sel ? 1'b0 : req0_v;
  assign a_req_1 = sel ? 1'b0 : req1_v;
  assign b_req_0 = sel ? req0_v : 1'b0;
  assign b_req_1 = sel ? req1_v : 1'b0;
  assign obs_ready0   = sel ? b_ready_0 : a_ready_0;
  assign obs_ready1   = sel ? b_ready_1 : a_ready_1;
  assign obs_busy     = sel ? b_busy : a_busy;
  assign obs_mem_en   = sel ? b_mem_en : a_mem_en;
  assign obs_line     = sel ? b_line : a_line;
  assign obs_mem_addr = sel ? {26'd0, b_mem_addr} : {18'd0, a_mem_addr};

  l2_refill_arbiter u_dut (
    .clk(clk), .rstn(rstn),
    .req_0(a_req_0), .addr_0(addr0_v), .ready_0(a_ready_0),
    .req_1(a_req_1), .addr_1(addr1_v), .ready_1(a_ready_1),
    .line_data(a_line), .busy(a_busy), .mem_en(a_mem_en),
    .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata)
`ifdef REFILL_PERF_EN
    , .refill_cnt_0(a_rc0), .refill_cnt_1(a_rc1), .wait_cycles(a_wait)
`endif
  );

  l2_refill_arbiter #(.BASE_ADDR(32'h40), .DEPTH_WORDS(32'h28)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .req_0(b_req_0), .addr_0(addr0_v), .ready_0(b_ready_0),
    .req_1(b_req_1), .addr_1(addr1_v), .ready_1(b_ready_1),
    .line_data(b_line), .busy(b_busy), .mem_en(b_mem_en),
    .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata)
`ifdef REFILL_PERF_EN
    , .refill_cnt_0(b_rc0), .refill_cnt_1(b_rc1), .wait_cycles(b_wait)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memories: word i holds tag + i, one cycle read latency.
  always @(posedge clk) begin
    if (a_mem_en) a_mem_rdata <= 32'hA000_0000 + {18'd0, a_mem_addr};
    if (b_mem_en) b_mem_rdata <= 32'hB000_0000 + {26'd0, b_mem_addr};
  end

  function automatic logic [511:0] model_line(input logic [31:0] base, input logic [31:0] depth,
                                              input logic [31:0] tag, input logic [25:0] la);
    logic [511:0] r;
    logic [31:0]  byte_a;
    logic [31:0]  idx;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      byte_a = {la, 6'd0} + 32'(k * 4);
      idx    = (byte_a - base) >> 2;
      if (byte_a >= base && idx < depth) r[k*32 +: 32] = tag + idx;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_maddr(input logic [31:0] base, input logic [25:0] la,
                                              input int k, input int aw);
    logic [31:0] byte_a;
    byte_a = {la, 6'd0} + 32'(k * 4);
    return ((byte_a - base) >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

  function automatic logic [25:0] rand_line();
    return 26'($urandom_range(0, 32'h301));
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0_v = 1'b0;
    req1_v = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit          inst;
    bit          port;
    logic [25:0] la;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  // Single refill from IDLE on the chosen instance/port, checking the whole transaction.
  task automatic run_vec(input vec_t v);
    int           k;
    int           bad;
    bit           other;
    logic [1:0]   rdy;
    logic [31:0]  base;
    logic [31:0]  depth;
    logic [31:0]  tag;
    int           aw;
    base  = v.inst ? 32'h40 : 32'h0;
    depth = v.inst ? 32'h28 : 32'h3000;
    tag   = v.inst ? 32'hB000_0000 : 32'hA000_0000;
    aw    = v.inst ? 6 : 14;
    sel   = v.inst;
    if (v.port) begin req1_v = 1'b1; addr1_v = v.la; end
    else        begin req0_v = 1'b1; addr0_v = v.la; end
    k = 0; bad = 0; other = 1'b0; rdy = 2'b00;
    while (rdy == 2'b00 && k < 40) begin
      @(negedge clk);
      k++;
      if (k <= 16 && (!obs_mem_en || obs_mem_addr != model_maddr(base, v.la, k - 1, aw))) bad++;
      if (v.port ? obs_ready0 : obs_ready1) other = 1'b1;
      rdy = v.port ? {obs_ready1, 1'b0} : {1'b0, obs_ready0};
    end
    chk("vec_latency", 512'(k), 512'd18);
    chk("vec_mem_addr_seq", 512'(bad), 512'd0);
    chk("vec_other_ready", 512'(other), 512'd0);
    chk("vec_busy_resp", 512'(obs_busy), 512'd1);
    chk("vec_word0", 512'(obs_line[31:0]), 512'(v.w0));
    chk("vec_word15", 512'(obs_line[511:480]), 512'(v.w15));
    chk("vec_line", obs_line, model_line(base, depth, tag, v.la));
    req0_v = 1'b0;
    req1_v = 1'b0;
    @(negedge clk);
    chk("vec_busy_idle", 512'(obs_busy), 512'd0);
  endtask

  initial begin
    vec_t         vecs [8];
    int           k;
    int           kstart;
    int           wcount;
    int           saw;
    bit           first;
    bit           gnt;
    bit           m_last;
    logic [1:0]   rdy;
    logic [25:0]  exp_la;
    logic [511:0] line_s;

    vecs[0] = '{1'b0, 1'b0, 26'h1,   32'hA000_0010, 32'hA000_001F};
    vecs[1] = '{1'b0, 1'b1, 26'h2,   32'hA000_0020, 32'hA000_002F};
    vecs[2] = '{1'b0, 1'b1, 26'h2FF, 32'hA000_2FF0, 32'hA000_2FFF};
    vecs[3] = '{1'b0, 1'b0, 26'h300, 32'h0,         32'h0};
    vecs[4] = '{1'b0, 1'b0, 26'h0,   32'hA000_0000, 32'hA000_000F};
    vecs[5] = '{1'b1, 1'b0, 26'h0,   32'h0,         32'h0};
    vecs[6] = '{1'b1, 1'b0, 26'h3,   32'hB000_0020, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 26'h1,   32'hB000_0000, 32'hB000_000F};

    n_checks = 0; n_fail = 0;
    sel = 1'b0; rstn = 1'b0; req0_v = 1'b0; req1_v = 1'b0; addr0_v = 26'd0; addr1_v = 26'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 512'({a_ready_1, a_ready_0}), 512'd0);
    chk("rst_line", a_line, 512'd0);
    chk("rst_busy", 512'({b_busy, a_busy}), 512'd0);
    chk("rst_mem_en", 512'(a_mem_en), 512'd0);
    chk("rst_mem_addr", 512'(a_mem_addr), 512'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Simultaneous requests from reset: port 0 first, port 1 one line later.
    do_reset();
    sel = 1'b0;
    req0_v = 1'b1; addr0_v = 26'h0; req1_v = 1'b1; addr1_v = 26'h2;
    for (int i = 0; i < 2; i++) begin
      k = 0; rdy = 2'b00;
      while (rdy == 2'b00 && k < 45) begin
        @(negedge clk); k++;
        rdy = {obs_ready1, obs_ready0};
      end
      chk("tie_latency", 512'(k), (i == 0) ? 512'd18 : 512'd19);
      chk("tie_port", 512'(rdy), (i == 0) ? 512'd1 : 512'd2);
      chk("tie_line", obs_line, model_line(32'h0, 32'h3000, 32'hA000_0000, (i == 0) ? 26'h0 : 26'h2));
      if (i == 0) req0_v = 1'b0; else req1_v = 1'b0;
    end

    // Both ports held with immediate re-request: strict alternation over 8 lines.
    do_reset();
    sel = 1'b0; wcount = 0; gnt = 1'b0;
    req0_v = 1'b1; addr0_v = 26'h10; req1_v = 1'b1; addr1_v = 26'h20;
    for (int i = 0; i < 8; i++) begin
      k = 0; rdy = 2'b00; exp_la = 26'd0; line_s = '0;
      while (rdy == 2'b00 && k < 45) begin
        @(negedge clk); k++;
        rdy = {obs_ready1, obs_ready0};
        if (rdy != 2'b00) begin
          line_s = obs_line;
          exp_la = gnt ? addr1_v : addr0_v;
          if (i == 7) begin
            req0_v = 1'b0; req1_v = 1'b0;
          end else if (gnt) begin
            addr1_v = addr1_v + 26'd1;
          end else begin
            addr0_v = addr0_v + 26'd1;
          end
        end
        if (obs_busy && (gnt ? req0_v : req1_v)) wcount++;
      end
      chk("alt_latency", 512'(k), (i == 0) ? 512'd18 : 512'd19);
      chk("alt_port", 512'(rdy), gnt ? 512'd2 : 512'd1);
      chk("alt_line", line_s, model_line(32'h0, 32'h3000, 32'hA000_0000, exp_la));
      gnt = ~gnt;
    end
    repeat (2) @(negedge clk);
`ifdef REFILL_PERF_EN
    chk("perf_refill_0", 512'(a_rc0), 512'd4);
    chk("perf_refill_1", 512'(a_rc1), 512'd4);
    chk("perf_wait", 512'(a_wait), 512'(wcount));
`endif

    // Reset in the middle of a burst aborts it without a ready pulse.
    do_reset();
    sel = 1'b0; req0_v = 1'b1; addr0_v = 26'h5;
    repeat (8) @(negedge clk);
    chk("abort_cnt7_addr", 512'(a_mem_addr), 512'h57);
    rstn = 1'b0;
    #1;
    chk("abort_busy", 512'(a_busy), 512'd0);
    chk("abort_mem_en", 512'(a_mem_en), 512'd0);
    chk("abort_line", a_line, 512'd0);
    req0_v = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (a_ready_0 || a_ready_1 || a_busy) saw++;
    end
    chk("abort_no_ready", 512'(saw), 512'd0);
    run_vec('{1'b0, 1'b0, 26'h7, 32'hA000_0070, 32'hA000_007F});

    // Randomized traffic against the round-robin reference model.
    do_reset();
    sel = 1'b0; first = 1'b1; m_last = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (!req0_v && $urandom_range(0, 1) == 1) begin req0_v = 1'b1; addr0_v = rand_line(); end
      if (!req1_v && $urandom_range(0, 1) == 1) begin req1_v = 1'b1; addr1_v = rand_line(); end
      if (req0_v && $urandom_range(0, 3) == 0) addr0_v = rand_line();
      if (req1_v && $urandom_range(0, 3) == 0) addr1_v = rand_line();
      if (!req0_v && !req1_v) begin req0_v = 1'b1; addr0_v = rand_line(); end
      gnt    = (req0_v && req1_v) ? ~m_last : req1_v;
      exp_la = gnt ? addr1_v : addr0_v;
      m_last = gnt;
      kstart = first ? 1 : 2;
      k = 0; rdy = 2'b00;
      while (rdy == 2'b00 && k < 45) begin
        @(negedge clk); k++;
        rdy = {obs_ready1, obs_ready0};
        if (rdy == 2'b00 && k >= kstart) begin
          if ($urandom_range(0, 3) == 0) begin
            if (gnt) addr1_v = rand_line(); else addr0_v = rand_line();
          end
          if ($urandom_range(0, 7) == 0) begin
            if (gnt) begin req0_v = 1'b1; addr0_v = rand_line(); end
            else     begin req1_v = 1'b1; addr1_v = rand_line(); end
          end
        end
      end
      chk("rnd_latency", 512'(k), first ? 512'd18 : 512'd19);
      chk("rnd_port", 512'(rdy), gnt ? 512'd2 : 512'd1);
      chk("rnd_line", obs_line, model_line(32'h0, 32'h3000, 32'hA000_0000, exp_la));
      if (gnt) req1_v = 1'b0; else req0_v = 1'b0;
      first = 1'b0;
    end
    req0_v = 1'b0; req1_v = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_refill_arbiter.md
Name: l2_refill_arbiter

Overview:
- Shares one single-port, 32-bit synchronous word memory (1-cycle read latency) between two L2 line-refill requesters: port 0 = instruction side, port 1 = data side.
- Arbitrates round-robin and sequences a 16-word burst per request.
- Assembles each burst into a 512-bit line and returns it with a one-cycle ready pulse.
- Sits between the L2 miss logic and the backing ROM/RAM, replacing the per-port sequencers.

Parameters:
- BASE_ADDR, 32'h0: byte address of memory word 0; must be 64-byte aligned.
- DEPTH_WORDS, 32'h3000: number of 32-bit words in the backing memory.
- AW, clogb2(DEPTH_WORDS-1): width of mem_addr.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_0  in  1  refill request, port 0; held until ready_0
- addr_0  in  26  line address (byte address [31:6]), port 0
- ready_0  out  1  one-cycle pulse: line_data valid for port 0
- req_1  in  1  refill request, port 1
- addr_1  in  26  line address, port 1
- ready_1  out  1  one-cycle pulse: line_data valid for port 1
- line_data  out  512  assembled line; word k in bits [32k+31:32k]; shared by both ports
- busy  out  1  high whenever state != IDLE
- mem_en  out  1  memory read enable
- mem_addr  out  AW  memory word index
- mem_rdata  in  32  memory data; valid the cycle after mem_en

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, ready_0=ready_1=0, line_data=0, mem_en=0, mem_addr=0, cnt=0, last_grant=1 (so port 0 wins the first tie).
- States: IDLE, BURST, DRAIN, RESP.
- IDLE:
  - Any req -> BURST. Latch gnt and the granted addr into line_r.
  - Single request: that port. Both requesting: the port != last_grant.
  - Update last_grant on grant. cnt=0.
- BURST (16 cycles, cnt 0..15):
  - mem_en=1. Word address w = {line_r, cnt} - BASE_ADDR[31:2], computed at 32-bit width.
  - mem_addr = w[AW-1:0].
  - Record a per-word invalid flag: {line_r,cnt} < BASE_ADDR[31:2] OR w >= DEPTH_WORDS.
  - From cnt=1 on, capture mem_rdata for word cnt-1 into line_data, or 0 if that word's delayed invalid flag is set.
  - cnt=15 -> DRAIN.
- DRAIN (1 cycle): mem_en=0; capture word 15 the same way. -> RESP.
- RESP (1 cycle): ready_<gnt>=1, the other ready=0. -> IDLE.
- Latency: grant cycle (IDLE->BURST edge) to ready pulse = 18 cycles. Back-to-back throughput = one line per 19 cycles.
- line_data holds its value until the next burst begins overwriting it. It is guaranteed only in the ready cycle.
- Requester handshake:
  - Requester must deassert req in the cycle after ready. A req still high in IDLE is treated as a new request.
  - Changing addr while req is high and ungranted is legal. Changing it after grant has no effect on the current burst.
- Neither req is sampled outside IDLE. A losing request waits; no requests are dropped.
- cnt wraps 15->0 only via the IDLE reentry. A line spanning the memory end: in-range words carry data, the rest read 0.
- Reset asserted mid-burst aborts immediately. No ready pulse; outputs return to reset values.
- mem_addr is held (not reset to 0) outside BURST, to reduce toggling.

Optional Feature:
- Macro REFILL_PERF_EN.
- Defined:
  - Adds outputs refill_cnt_0[31:0], refill_cnt_1[31:0]: completed lines per port, incremented on the ready pulse.
  - Adds wait_cycles[31:0]: cycles in which some req is high but not being serviced (IDLE with pending req counts 0; any non-IDLE cycle with the non-granted port's req high counts 1).
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Memory word i = 32'hA000_0000+i, BASE_ADDR=0. req_0, addr_0=26'h1 -> mem_addr 16..31 on consecutive cycles; ready_0 pulses 18 cycles after grant; line_data word k = 32'hA000_0010+k; ready_1 stays 0.
- req_0 and req_1 rise in the same cycle from reset (addr 0 and 2) -> port 0 served first, then port 1. Pulse gap 19 cycles; port 1 line words = 32'hA000_0020+k.
- Both requests held continuously with immediate re-request after each ready -> grants alternate 0,1,0,1 over 8 lines; no port starves.
- BASE_ADDR=32'h40, addr_0=26'h0 -> all 16 words invalid, line_data=0. Then addr_0=26'h300 with DEPTH_WORDS=32'h3000 -> 16 words out of range, line_data=0, ready still pulses.
- Assert rstn low at cnt=7 of a burst -> ready never pulses, busy=0 and mem_en=0 immediately. A new request after release completes normally.
- With REFILL_PERF_EN, run the alternation test -> refill_cnt_0=4, refill_cnt_1=4; wait_cycles equals the sum of non-granted req-high cycles observed by the bench.
